piso_tx_ctrl: RTL and testbench
===============================

# piso_tx_ctrl

Transmit controller that sequences a parallel-in/serial-out shift path: it accepts parallel words through a valid/ready handshake and shifts each one out MSB-first. Each bit is held for a programmable number of clocks, and a programmable idle gap follows every frame. It sits between a byte-producing source (counter, ROM reader, FSM) and a serial line or LED/scope probe. It owns the shift register, the bit counter and the baud divider, so the source never has to time load/shift pulses.

## Interface
- WIDTH, 8: bits per frame, ≥2.
- DIV, 4: clock cycles each bit is held on ser_out, ≥1.
- GAP, 1: idle bit-periods (GAP*DIV cycles) inserted after each frame, ≥0.

- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- in_valid  input  1  source offers in_data this cycle.
- in_data  input  WIDTH  parallel word; sampled only on the accept cycle.
- in_ready  output  1  controller can accept a word (high only in IDLE, low while reset is high).
- ser_out  output  1  serial data, MSB first; 0 when not in SHIFT.
- ser_valid  output  1  high on every cycle a frame bit is driven on ser_out.
- done  output  1  one-cycle pulse on the last cycle of the last bit of a frame.
- busy  output  1  high in SHIFT and GAP.

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE: in_ready=1. Accept occurs when in_valid & in_ready are both high at a rising edge. On accept, capture in_data into the shift register, clear the bit counter and divider, and go to SHIFT.
- SHIFT:
  - ser_out = sh[WIDTH-1] and ser_valid=1.
  - The divider counts 0..DIV-1. On wrap it shifts sh left by one (LSB filled with 0) and increments the bit counter.
  - On the divider wrap with bit counter = WIDTH-1, assert done and go to GAP if GAP>0, else IDLE.
- GAP: ser_out=0, ser_valid=0, busy=1. Hold for GAP*DIV cycles, then go to IDLE.
- in_valid while not in IDLE is ignored. No capture takes place and the source must hold the word.
- Changes to in_data after accept have no effect on the current frame.
- Counter widths are $clog2 of their ranges. The bit counter never exceeds WIDTH-1 and the divider never exceeds DIV-1.
- DIV=1: one bit per cycle; the divider is constant-wrap.
- GAP=0: go SHIFT→IDLE directly.

## Timing
Cycle 0 is the cycle in which the accept handshake occurs.

- Reset values (the cycle after reset is sampled high): state IDLE, ser_out=0, ser_valid=0, done=0, busy=0, counters 0. in_ready=0 during the reset cycle and 1 the cycle after.
- Latency: the first bit (in_data[WIDTH-1]) is on ser_out in cycle 1.
- Bit k (k=0 is the MSB) occupies cycles 1+k*DIV .. (k+1)*DIV.
- done is high in cycle WIDTH*DIV only.
- GAP occupies cycles WIDTH*DIV+1 .. WIDTH*DIV+GAP*DIV.
- in_ready rises in cycle WIDTH*DIV+GAP*DIV+1.
- Minimum accept-to-accept period: WIDTH*DIV + GAP*DIV + 1 cycles.
- Reset mid-frame (SHIFT or GAP): the next cycle is IDLE with all outputs at reset values. The partial frame is discarded and no done pulse is issued.
- Reset coincident with in_valid: no accept, in_ready stays low that cycle.
- Outputs ser_out, ser_valid, done and busy are registered or derived only from state/registers, never combinationally from in_valid or in_data.

## Test plan
- WIDTH=8, DIV=4, GAP=1, in_data=0xA5 with in_valid held high:
  - ser_out shows 1,0,1,0,0,1,0,1, each bit for 4 cycles, in cycles 1–32.
  - ser_valid is high for exactly 32 cycles and done is high in cycle 32 only.
  - in_ready is low in cycles 1–36 and high in cycle 37, giving a 37-cycle period for back-to-back words.
- DIV=1, GAP=0, words 0xFF then 0x00 presented back-to-back:
  - ser_out shows 8 ones in cycles 1–8, then IDLE in cycle 9 with ser_out=0 and in_ready=1.
  - The second accept occurs in cycle 9 and its 8 zeros appear in cycles 10–17 with ser_valid=1.
- in_valid pulsed high with 0x3C in cycle 10 of a frame, while in_ready=0:
  - No capture occurs and the current frame completes unchanged.
  - 0x3C is only transmitted once it is presented again while in IDLE.
- Reset asserted in cycle 13 of a 0xA5 frame (DIV=4):
  - From cycle 14: ser_valid=0, busy=0, ser_out=0, in_ready=1, and no done pulse.
  - A new word 0x81 accepted afterwards shifts out as 1,0,0,0,0,0,0,1.
- Reset held high while in_valid=1: in_ready=0, no frame starts, and all outputs stay 0.
- Random words with random in_valid gaps (DIV=3, GAP=2): a scoreboard checks that the reconstructed bits equal the accepted words and that the done count equals the accept count.

Source files
------------

// File: rtl/piso_tx_ctrl.sv
// piso_tx_ctrl: parallel-in/serial-out transmit controller.
// Accepts WIDTH-bit words over a valid/ready handshake and shifts each one
// out MSB-first. Each bit is held for DIV clocks, and each frame is followed
// by an idle gap of GAP*DIV clocks.
//
// Ports:
//   clk       - single clock, rising edge
//   reset     - synchronous, active-high
//   in_valid  - source offers in_data
//   in_data   - parallel word, sampled on the accept cycle only
//   in_ready  - high in IDLE when reset is low
//   ser_out   - serial data, MSB first, 0 outside SHIFT
//   ser_valid - high while a frame bit is on ser_out
//   done      - one-cycle pulse on the last cycle of the last bit
//   busy      - high in SHIFT and GAP
module piso_tx_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             done,
  output logic             busy
);

  localparam int unsigned BIT_W    = $clog2(WIDTH);
  localparam int unsigned DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned GAP_CYC  = GAP * DIV;
  localparam int unsigned GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int unsigned BIT_LAST = WIDTH - 1;
  localparam int unsigned BIT_PEN  = WIDTH - 2;
  localparam int unsigned DIV_LAST = DIV - 1;
  localparam int unsigned DIV_PEN  = (DIV > 1) ? DIV - 2 : 0;
  localparam int unsigned GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh;
  logic [BIT_W-1:0] bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic last_div;
  logic last_bit;

  assign last_div = (div_cnt == DIV_W'(DIV_LAST));
  assign last_bit = (bit_cnt == BIT_W'(BIT_LAST));

  // Reset gates ready so a word offered during reset is never taken.
  assign in_ready = (state == ST_IDLE) && !reset;

  // State, datapath and registered outputs. Outputs are loaded one edge
  // ahead so that they describe the state being entered; done uses a
  // lookahead on the counters to land on the final cycle of the last bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      sh        <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      gap_cnt   <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            state     <= ST_SHIFT;
            sh        <= in_data;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            gap_cnt   <= '0;
            ser_out   <= in_data[WIDTH-1];
            ser_valid <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end

        ST_SHIFT: begin
          if (last_div) begin
            div_cnt <= '0;
            if (last_bit) begin
              // Frame finished: drop the line and move to the gap or idle.
              sh        <= '0;
              bit_cnt   <= '0;
              ser_out   <= 1'b0;
              ser_valid <= 1'b0;
              done      <= 1'b0;
              gap_cnt   <= '0;
              if (GAP_CYC > 0) begin
                state <= ST_GAP;
                busy  <= 1'b1;
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              sh      <= {sh[WIDTH-2:0], 1'b0};
              ser_out <= sh[WIDTH-2];
              bit_cnt <= bit_cnt + BIT_W'(1);
              // With DIV=1 the last bit lasts a single cycle.
              done    <= (DIV == 1) && (bit_cnt == BIT_W'(BIT_PEN));
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
            done    <= last_bit && (div_cnt == DIV_W'(DIV_PEN));
          end
        end

        ST_GAP: begin
          if (gap_cnt == GAP_W'(GAP_LAST)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          state     <= ST_IDLE;
          ser_out   <= 1'b0;
          ser_valid <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Bench for piso_tx_ctrl: three instances (DIV/GAP = 4/1, 1/0, 3/2).
// A frame-timing model tracks cycles since accept per instance; accepted
// words are expanded into an expected bit stream and word queue that a
// negedge monitor pops whenever the DUT drives a bit or pulses done.
module tb_piso_tx_ctrl;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst      [3];
  logic       in_valid [3];
  logic [7:0] in_data  [3];
  logic       rdy [3];
  logic       so  [3];
  logic       sv  [3];
  logic       dn  [3];
  logic       bz  [3];

  int div_a [3] = '{4, 1, 3};
  int gap_a [3] = '{1, 0, 2};

  // Model state: cycles since accept (-1 when idle).
  int rel      [3] = '{-1, -1, -1};
  int accepts  [3] = '{0, 0, 0};
  int dones    [3] = '{0, 0, 0};
  int vcnt     [3] = '{0, 0, 0};
  logic [7:0] recon [3];
  bit         q_bits  [3][$];
  logic [7:0] q_words [3][$];

  bit armed     = 1'b0;
  bit final_req = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  piso_tx_ctrl #(.WIDTH(8), .DIV(4), .GAP(1)) u0 (
    .clk(clk), .reset(rst[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(rdy[0]), .ser_out(so[0]), .ser_valid(sv[0]), .done(dn[0]), .busy(bz[0]));

  piso_tx_ctrl #(.WIDTH(8), .DIV(1), .GAP(0)) u1 (
    .clk(clk), .reset(rst[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(rdy[1]), .ser_out(so[1]), .ser_valid(sv[1]), .done(dn[1]), .busy(bz[1]));

  piso_tx_ctrl #(.WIDTH(8), .DIV(3), .GAP(2)) u2 (
    .clk(clk), .reset(rst[2]), .in_valid(in_valid[2]), .in_data(in_data[2]),
    .in_ready(rdy[2]), .ser_out(so[2]), .ser_valid(sv[2]), .done(dn[2]), .busy(bz[2]));

  task automatic chk(input string nm, input int inst, input logic [7:0] act,
                     input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[u%0d] t=%0t: got %0h expected %0h", nm, inst, $time, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input int inst);
    n_tests++;
    n_fail++;
    $display("FAIL %s[u%0d] t=%0t: got output with empty scoreboard, expected none",
             nm, inst, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: frame timing from the handshake rules.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int total;
      total = W * div_a[i] + gap_a[i] * div_a[i];
      if (rst[i]) begin
        if (rel[i] >= 1 && rel[i] < W * div_a[i]) accepts[i] <= accepts[i] - 1;
        rel[i] <= -1;
        q_bits[i].delete();
        q_words[i].delete();
        armed <= 1'b1;
      end else if (rel[i] < 0) begin
        if (in_valid[i]) begin
          rel[i]     <= 1;
          accepts[i] <= accepts[i] + 1;
          q_words[i].push_back(in_data[i]);
          for (int k = W - 1; k >= 0; k--)
            for (int d = 0; d < div_a[i]; d++)
              q_bits[i].push_back(in_data[i][k]);
        end
      end else if (rel[i] == total) begin
        rel[i] <= -1;
      end else begin
        rel[i] <= rel[i] + 1;
      end
    end
  end

  // Monitor: per-cycle timing checks plus scoreboard pops.
  always @(negedge clk) begin
    int  r;
    bit  exp_sv;
    bit  b;
    logic [7:0] w;
    if (armed) begin
      for (int i = 0; i < 3; i++) begin
        r      = rel[i];
        exp_sv = (r >= 1) && (r <= W * div_a[i]);
        chk("ser_valid", i, 8'(sv[i]), 8'(exp_sv));
        chk("busy",      i, 8'(bz[i]), 8'(r >= 1));
        chk("done",      i, 8'(dn[i]), 8'(r == W * div_a[i]));
        chk("in_ready",  i, 8'(rdy[i]), 8'((r < 0) && !rst[i]));
        if (!exp_sv) chk("ser_out_idle", i, 8'(so[i]), 8'd0);
        if (sv[i] === 1'b1) begin
          if (q_bits[i].size() == 0) fail_now("bit_stream", i);
          else begin
            b = q_bits[i].pop_front();
            chk("bit_stream", i, 8'(so[i]), 8'(b));
          end
          vcnt[i] = vcnt[i] + 1;
          if (vcnt[i] % div_a[i] == 0) recon[i] = {recon[i][6:0], so[i]};
        end
        if (dn[i] === 1'b1) begin
          if (q_words[i].size() == 0) fail_now("frame", i);
          else begin
            w = q_words[i].pop_front();
            chk("frame", i, recon[i], w);
          end
          dones[i] = dones[i] + 1;
          vcnt[i]  = 0;
          recon[i] = 8'd0;
        end
        if (rst[i]) begin
          vcnt[i]  = 0;
          recon[i] = 8'd0;
        end
      end
    end
    if (final_req) begin
      for (int i = 0; i < 3; i++) begin
        chk("done_count", i, 8'(dones[i]), 8'(accepts[i]));
        chk("queue_empty", i, 8'(q_words[i].size()), 8'd0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i]      = 1'b1;
      in_valid[i] = 1'b1;
      in_data[i]  = 8'hA5;
      recon[i]    = 8'd0;
    end
    // Reset held with in_valid high: nothing may start.
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      rst[i]      = 1'b0;
      in_valid[i] = 1'b0;
    end
    tick();

    // u0: 0xA5 with in_valid held, back-to-back frames.
    in_valid[0] = 1'b1;
    in_data[0]  = 8'hA5;
    repeat (80) tick();
    in_valid[0] = 1'b0;
    repeat (50) tick();

    // u0: 0x3C offered in cycle 10 of a frame is ignored, then sent from IDLE.
    in_valid[0] = 1'b1;
    in_data[0]  = 8'hA5;
    tick();
    in_valid[0] = 1'b0;
    repeat (9) tick();
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h3C;
    tick();
    in_valid[0] = 1'b0;
    repeat (40) tick();
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    repeat (40) tick();

    // u0: reset in cycle 13 of a frame, then 0x81.
    in_valid[0] = 1'b1;
    in_data[0]  = 8'hA5;
    tick();
    in_valid[0] = 1'b0;
    repeat (12) tick();
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    repeat (3) tick();
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h81;
    tick();
    in_valid[0] = 1'b0;
    repeat (40) tick();

    // u1: 0xFF then 0x00 back-to-back with DIV=1, GAP=0.
    in_valid[1] = 1'b1;
    in_data[1]  = 8'hFF;
    tick();
    in_data[1]  = 8'h00;
    repeat (9) tick();
    in_valid[1] = 1'b0;
    repeat (12) tick();

    // u2: random words with random valid gaps.
    for (int c = 0; c < 700; c++) begin
      in_valid[2] = ($urandom_range(0, 3) == 0);
      in_data[2]  = 8'($urandom);
      tick();
    end
    in_valid[2] = 1'b0;
    repeat (40) tick();

    final_req = 1'b1;
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
